// File: rtl/axis_requant_packer.sv
// axis_requant_packer: requantizes signed accumulators to int8 (scale, rounding
// shift, zero point, saturate) and packs OUT_WIDTH/8 bytes per output beat,
// flagging the beat that carries the final element with TLAST.
module axis_requant_packer #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int MULT_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic [31:0]            num_elements,
  input  logic [MULT_WIDTH-1:0]  scale_mult,
  input  logic [SHIFT_WIDTH-1:0] scale_shift,
  input  logic [7:0]             zero_point,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready
);

  localparam int PACK   = OUT_WIDTH / 8;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW     = IN_WIDTH + MULT_WIDTH;
  localparam int AW     = PW + 2;

  localparam logic signed [AW-1:0] SAT_MAX = AW'(127);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-128);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  // Job configuration captured when a start is accepted
  logic [31:0]                   num_r;
  logic signed [MULT_WIDTH-1:0]  mult_r;
  logic [SHIFT_WIDTH-1:0]        shift_r;
  logic [7:0]                    zp_r;

  logic [31:0] in_cnt;
  logic [31:0] out_cnt;

  // Pipeline stages
  logic                 s1_valid;
  logic signed [PW-1:0] s1_prod;
  logic                 s2_valid;
  logic [7:0]           s2_q;
  logic [LANE_W-1:0]    lane;
  logic [OUT_WIDTH-1:0] lanes;

  logic                 en;
  logic                 accept;
  logic                 start_go;
  logic                 final_hs;
  logic                 out_last;
  logic                 word_full;
  logic signed [PW-1:0] data_ext;
  logic signed [PW-1:0] mult_ext;
  logic signed [PW-1:0] prod_in;
  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] biased;
  logic signed [AW-1:0] shifted;
  logic signed [AW-1:0] sum_zp;
  logic [7:0]           q_next;
  logic [OUT_WIDTH-1:0] word_next;

  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == RUN) && (in_cnt < num_r) && en;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign start_go      = (state == IDLE) && start;
  assign final_hs      = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign out_last      = (out_cnt == num_r - 32'd1);
  assign word_full     = (lane == LANE_W'(PACK - 1));

  assign data_ext = PW'($signed(s_axis_tdata));
  assign mult_ext = PW'(mult_r);
  assign prod_in  = data_ext * mult_ext;

  // Rounding shift, zero point and saturation, all at full width so nothing wraps
  always_comb begin
    rnd = '0;
    if (shift_r != '0) begin
      rnd = AW'(1) <<< (shift_r - SHIFT_WIDTH'(1));
    end
    biased  = AW'(s1_prod) + rnd;
    shifted = biased >>> shift_r;
    sum_zp  = shifted + AW'($signed(zp_r));
    if (sum_zp > SAT_MAX) begin
      q_next = 8'h7F;
    end else if (sum_zp < SAT_MIN) begin
      q_next = 8'h80;
    end else begin
      q_next = sum_zp[7:0];
    end
  end

  // Merge the stage-2 byte into the partially filled word
  always_comb begin
    word_next                = lanes;
    word_next[8*lane +: 8]   = s2_q;
  end

  // Job control FSM: configuration latch, input count and TLAST checking
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      num_r   <= '0;
      mult_r  <= '0;
      shift_r <= '0;
      zp_r    <= '0;
      in_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_r   <= num_elements;
            mult_r  <= scale_mult;
            shift_r <= scale_shift;
            zp_r    <= zero_point;
            error   <= 1'b0;
            in_cnt  <= '0;
            if (num_elements != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            in_cnt <= in_cnt + 32'd1;
            if (s_axis_tlast != (in_cnt == num_r - 32'd1)) begin
              error <= 1'b1;
            end
          end
          if (final_hs) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: multiply, requantize, pack and present words on m_axis
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_valid      <= 1'b0;
      s1_prod       <= '0;
      s2_valid      <= 1'b0;
      s2_q          <= '0;
      lane          <= '0;
      lanes         <= '0;
      out_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (start_go) begin
        lane    <= '0;
        lanes   <= '0;
        out_cnt <= '0;
      end else if (en) begin
        s1_valid <= accept;
        if (accept) begin
          s1_prod <= prod_in;
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_q <= q_next;
        end
        // A load here overrides the tvalid clear above when a handshake and
        // the next word coincide, so back-to-back words need no bubble.
        if (s2_valid) begin
          out_cnt <= out_cnt + 32'd1;
          if (word_full || out_last) begin
            m_axis_tdata  <= word_next;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= out_last;
            lanes         <= '0;
            lane          <= '0;
          end else begin
            lanes <= word_next;
            lane  <= lane + LANE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_requant_packer.sv
// Self-checking bench for axis_requant_packer: a queue-based reference model
// predicts every output beat; directed jobs also pin literal words.
module tb_axis_requant_packer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [31:0] num_elements;
  logic [15:0] scale_mult;
  logic [4:0]  scale_shift;
  logic [7:0]  zero_point;
  logic        busy, done, error;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;

  int checks = 0;
  int fails  = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          din[$];
  bit          stall_mode = 1'b0;
  int          tr_ph = 0;
  bit          hold = 1'b0;
  logic [32:0] held = '0;

  axis_requant_packer #(
    .IN_WIDTH   (32),
    .OUT_WIDTH  (32),
    .MULT_WIDTH (16),
    .SHIFT_WIDTH(5)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .start        (start),
    .num_elements (num_elements),
    .scale_mult   (scale_mult),
    .scale_shift  (scale_shift),
    .zero_point   (zero_point),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference requantization in plain 64-bit arithmetic
  function automatic logic [7:0] requant(input int acc, input int mult, input int shift, input int zp);
    longint p;
    longint v;
    p = longint'(acc) * longint'(mult);
    if (shift > 0) p = p + (longint'(1) << (shift - 1));
    v = (p >>> shift) + longint'(zp);
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return v[7:0];
  endfunction

  // Output ready: always high, or 7 cycles high / 10 cycles low when stalling
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (stall_mode) begin
        m_axis_tready = (tr_ph < 7);
        tr_ph = (tr_ph + 1) % 17;
      end else begin
        m_axis_tready = 1'b1;
        tr_ph = 0;
      end
    end
  end

  // Compare process: every handshake against the model, plus stall stability
  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        hold = 1'b0;
      end else begin
        if (hold)
          check("stall_stable", {31'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {31'd0, 1'b1, held});
        if (m_axis_tvalid && m_axis_tready) begin
          got_q.push_back({m_axis_tlast, m_axis_tdata});
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_beat: actual 0x%0h required no beat", {m_axis_tlast, m_axis_tdata});
          end else begin
            check("m_axis_word", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, exp_q.pop_front()});
          end
        end
        hold = m_axis_tvalid && !m_axis_tready;
        held = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  task automatic run_job(input int num, input int mult, input int shift, input int zp,
                         input int bad_idx, input int abort_after, input bit exp_err);
    logic [31:0] w;
    int          cyc;
    bit          to;
    w = '0;
    for (int i = 0; i < num; i++) begin
      w[8*(i%4) +: 8] = requant(din[i], mult, shift, zp);
      if ((i % 4 == 3) || (i == num - 1)) begin
        exp_q.push_back({1'(i == num - 1), w});
        w = '0;
      end
    end
    got_q.delete();
    @(posedge aclk);
    #1;
    num_elements = num;
    scale_mult   = 16'(mult);
    scale_shift  = 5'(shift);
    zero_point   = 8'(zp);
    start        = 1'b1;
    @(posedge aclk);
    #1;
    check("start_flags", {61'd0, busy, done, error}, {61'd0, 1'(num > 0), 1'(num == 0), 1'b0});
    for (int i = 0; i < num; i++) begin
      if (i == abort_after) break;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = din[i];
      s_axis_tlast  = (i == num - 1) ^ (i == bad_idx);
      cyc = 0;
      to  = 1'b0;
      forever begin
        @(negedge aclk);
        if (s_axis_tready) break;
        cyc++;
        if (cyc > 2000) begin
          to = 1'b1;
          break;
        end
      end
      if (to) begin
        checks++;
        fails++;
        $display("FAIL feed_timeout: element %0d accepted=0 required=1", i);
        break;
      end
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (abort_after >= 0 && abort_after < num) begin
      areset = 1'b1;
      #1;
      check("midjob_reset_outputs",
            {27'd0, busy, done, error, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
            64'd0);
      exp_q.delete();
      @(posedge aclk);
      #1;
      areset = 1'b0;
      start  = 1'b0;
      return;
    end
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge aclk);
      cyc++;
    end
    check("done_reached", {63'd0, done}, 64'd1);
    check("job_error", {63'd0, error}, {63'd0, exp_err});
    check("busy_low_at_done", {63'd0, busy}, 64'd0);
    check("all_words_seen", 64'(exp_q.size()), 64'd0);
    @(posedge aclk);
    #1;
    start = 1'b0;
    @(posedge aclk);
    #1;
    check("done_release", {63'd0, done}, 64'd0);
  endtask

  task automatic fill_ramp(input int n);
    din.delete();
    for (int i = 1; i <= n; i++) din.push_back(i);
  endtask

  initial begin
    int mult, shift, zp, r;
    areset        = 1'b1;
    start         = 1'b0;
    num_elements  = '0;
    scale_mult    = '0;
    scale_shift   = '0;
    zero_point    = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    #1;
    check("reset_outputs",
          {27'd0, busy, done, error, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 64'd0);
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    // T1: plain pass-through packing
    fill_ramp(8);
    run_job(8, 1, 0, 0, -1, -1, 1'b0);
    check("t1_count", 64'(got_q.size()), 64'd2);
    check("t1_word0", {31'd0, got_q[0]}, {31'd0, 1'b0, 32'h04030201});
    check("t1_word1", {31'd0, got_q[1]}, {31'd0, 1'b1, 32'h08070605});

    // T2: saturation both ways and rounding shift
    din.delete();
    din.push_back(300); din.push_back(-300); din.push_back(5); din.push_back(-5);
    run_job(4, 1, 1, 0, -1, -1, 1'b0);
    check("t2_word0", {31'd0, got_q[0]}, {31'd0, 1'b1, 32'hFE03807F});

    // Negative multiplier, zero point and floor-style arithmetic shift
    din.delete();
    din.push_back(7); din.push_back(-7); din.push_back(100); din.push_back(0);
    run_job(4, -3, 2, 10, -1, -1, 1'b0);
    check("scaled_word0", {31'd0, got_q[0]}, {31'd0, 1'b1, 32'h0ABF0F05});

    // T3: partial final word, then an empty job
    fill_ramp(6);
    run_job(6, 1, 0, 0, -1, -1, 1'b0);
    check("t3_word0", {31'd0, got_q[0]}, {31'd0, 1'b0, 32'h04030201});
    check("t3_word1", {31'd0, got_q[1]}, {31'd0, 1'b1, 32'h00000605});
    din.delete();
    run_job(0, 1, 0, 0, -1, -1, 1'b0);
    check("t3_empty_no_beats", 64'(got_q.size()), 64'd0);

    // T4: random data under output backpressure
    din.delete();
    mult  = $urandom_range(0, 65535) - 32768;
    shift = $urandom_range(0, 14);
    zp    = $urandom_range(0, 255) - 128;
    for (int i = 0; i < 64; i++) begin
      r = int'($urandom());
      din.push_back(r >>> $urandom_range(0, 24));
    end
    stall_mode = 1'b1;
    run_job(64, mult, shift, zp, -1, -1, 1'b0);
    stall_mode = 1'b0;
    check("t4_count", 64'(got_q.size()), 64'd16);

    // T5: early input TLAST flags error; following job clears it
    fill_ramp(4);
    run_job(4, 1, 0, 0, 2, -1, 1'b1);
    check("t5_count", 64'(got_q.size()), 64'd1);
    check("t5_tlast", {63'd0, got_q[0][32]}, 64'd1);
    run_job(4, 1, 0, 0, -1, -1, 1'b0);

    // T6: reset mid-job, then a fresh job
    fill_ramp(8);
    run_job(8, 1, 0, 0, -1, 5, 1'b0);
    fill_ramp(4);
    run_job(4, 1, 0, 0, -1, -1, 1'b0);
    check("t6_word0", {31'd0, got_q[0]}, {31'd0, 1'b1, 32'h04030201});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: finished=0 required=1");
    $fatal(1, "timeout");
  end

endmodule
